// File: rtl/jk_pkg.sv
// jk_pkg: shared JK control codes and small helpers for building per-bit codes.
//   JK_HOLD / JK_CLR / JK_SET / JK_TGL are the 2-bit codes applied to jk_cell.
package jk_pkg;

   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_CLR  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TGL  = 2'b11;

   // Drive a bit to an absolute value (loads and wraps).
   function automatic logic [1:0] jk_force(input logic b);
      return b ? JK_SET : JK_CLR;
   endfunction

   // Relative update: toggle bits that change, hold the rest.
   function automatic logic [1:0] jk_step(input logic flip);
      return flip ? JK_TGL : JK_HOLD;
   endfunction

endpackage

// File: rtl/jk_cell.sv
// jk_cell: single JK flip-flop with asynchronous active-low reset to 0.
//   clk   : rising-edge clock
//   rst_n : asynchronous reset, active-low
//   jk    : 2-bit code {J,K}: 00 hold, 01 clear, 10 set, 11 toggle
//   q     : stored bit
//   qbar  : complement of q (follows q at all times, including reset)
module jk_cell
   import jk_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] jk,
   output logic       q,
   output logic       qbar
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= 1'b0;
      end else begin
         unique case (jk)
            JK_HOLD: q <= q;
            JK_CLR:  q <= 1'b0;
            JK_SET:  q <= 1'b1;
            JK_TGL:  q <= ~q;
         endcase
      end
   end

   assign qbar = ~q;

endmodule

// File: rtl/jk_counter.sv
// jk_counter: modulo-MODULUS up/down counter built from WIDTH JK cells.
//   clk   : rising-edge clock
//   rst_n : asynchronous reset, active-low (q=0)
//   en    : count enable
//   up    : direction, 1 = up, 0 = down
//   load  : synchronous parallel load (priority over en)
//   d     : load value, values >= MODULUS load MODULUS-1
//   q     : registered count, qbar its complement
//   tc    : terminal count, combinational
// Build option: define JK_COUNTER_SAT_EN to saturate at the ends instead of wrapping.
module jk_counter
   import jk_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic             tc
);

   localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   logic [WIDTH-1:0]      q_int;
   logic [WIDTH-1:0]      qbar_int;
   logic [WIDTH-1:0]      q_inc;
   logic [WIDTH-1:0]      q_dec;
   logic [WIDTH-1:0]      ld_val;
   logic                  at_max;
   logic                  at_zero;
   logic [WIDTH-1:0][1:0] jk_code;

   assign q_inc   = q_int + WIDTH'(1);
   assign q_dec   = q_int - WIDTH'(1);
   // >= rather than == so an out-of-range value can only ever fall back into range
   assign at_max  = (q_int >= Q_MAX);
   assign at_zero = (q_int == '0);
   // extra top bit lets MODULUS == 2**WIDTH compare correctly
   assign ld_val  = ({1'b0, d} >= MOD_EXT) ? Q_MAX : d;

   always_comb begin
      jk_code = '0;
      for (int i = 0; i < WIDTH; i++) begin
         jk_code[i] = JK_HOLD;
         if (load) begin
            jk_code[i] = jk_force(ld_val[i]);
         end else if (en) begin
            if (up) begin
               if (at_max) begin
`ifdef JK_COUNTER_SAT_EN
                  jk_code[i] = JK_HOLD;
`else
                  jk_code[i] = jk_force(1'b0);
`endif
               end else begin
                  jk_code[i] = jk_step(q_int[i] ^ q_inc[i]);
               end
            end else begin
               if (at_zero) begin
`ifdef JK_COUNTER_SAT_EN
                  jk_code[i] = JK_HOLD;
`else
                  jk_code[i] = jk_force(Q_MAX[i]);
`endif
               end else begin
                  jk_code[i] = jk_step(q_int[i] ^ q_dec[i]);
               end
            end
         end
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      jk_cell u_cell (
         .clk  (clk),
         .rst_n(rst_n),
         .jk   (jk_code[g]),
         .q    (q_int[g]),
         .qbar (qbar_int[g])
      );
   end

   assign q    = q_int;
   assign qbar = qbar_int;
   assign tc   = en & ((up & (q_int == Q_MAX)) | (~up & at_zero));

endmodule

// File: doc/jk_counter.md
JK_COUNTER -- requirements
Module: jk_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits.
REQ-002 SHALL have parameter MODULUS, default 10, count range 0..MODULUS-1; legal range 2..2**WIDTH.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  count enable, sampled on rising clk.
REQ-006 SHALL have port up  input  1  direction: 1 = up, 0 = down.
REQ-007 SHALL have port load  input  1  synchronous parallel load strobe.
REQ-008 SHALL have port d  input  WIDTH  parallel load value.
REQ-009 SHALL have port q  output  WIDTH  registered count.
REQ-010 SHALL have port qbar  output  WIDTH  registered complement of q.
REQ-011 SHALL have port tc  output  1  terminal-count flag, combinational.

Function
REQ-012 Each count bit SHALL be one JK cell driven by a 2-bit code: 00 hold, 01 clear, 10 set, 11 toggle.
REQ-013 All state changes SHALL occur on the rising clk edge, with one-cycle latency from sampled inputs to q.
REQ-014 qbar SHALL equal ~q at every instant, including during and after reset.
REQ-015 Priority SHALL be load over en: load=1 loads d regardless of en and up.
REQ-016 A load with d >= MODULUS SHALL load MODULUS-1.
REQ-017 A load SHALL drive each bit with a set or clear code only, never a toggle.
REQ-018 With load=0 and en=0, every bit SHALL receive the hold code and q SHALL be unchanged.
REQ-019 With load=0, en=1, up=1 and q < MODULUS-1, q SHALL become q+1, using toggle codes on the bits that change.
REQ-020 With load=0, en=1, up=0 and q > 0, q SHALL become q-1, using toggle codes on the bits that change.
REQ-021 Wrap-around SHALL be as follows: up at MODULUS-1 goes to 0, and down at 0 goes to MODULUS-1. Wrap bits SHALL be driven with set or clear codes.
REQ-022 tc SHALL equal en & ((up & q==MODULUS-1) | (~up & q==0)), and SHALL be 0 whenever en=0.
REQ-023 q SHALL never hold a value >= MODULUS when reached through any legal sequence.

Reset
REQ-024 rst_n=0 SHALL immediately force q=0 and qbar all ones, independent of clk.
REQ-025 Reset asserted mid-count SHALL abandon the current count with no residual state.
REQ-026 On the first rising edge after rst_n deasserts, the block SHALL respond normally to load and en.
REQ-027 During reset, tc SHALL follow REQ-022 with q=0.

Configuration
REQ-028 Macro JK_COUNTER_SAT_EN SHALL select saturating mode when defined.
REQ-029 When defined, up at MODULUS-1 and down at 0 SHALL issue hold codes, so q stays put; tc behaves as in REQ-022.
REQ-030 When undefined, wrap-around per REQ-021 SHALL apply.

Structure
REQ-031 A shared package jk_pkg SHALL hold the JK code constants JK_HOLD=2'b00, JK_CLR=2'b01, JK_SET=2'b10 and JK_TGL=2'b11.
REQ-032 Sub-module jk_cell SHALL be a single JK flop with inputs clk, rst_n and jk[1:0] and outputs q and qbar, with async active-low reset to q=0.
REQ-033 jk_counter SHALL instantiate WIDTH jk_cell instances; all next-state logic SHALL reside in jk_counter as per-bit code generation.

Verification (WIDTH=4, MODULUS=10)
REQ-034 Up count: from reset, en=1, up=1 for 11 edges -> q = 1,2,...,9,0,1; tc=1 only while q=9.
REQ-035 Down wrap: q=0, en=1, up=0, one edge -> q=9; tc=1 at q=0 beforehand.
REQ-036 Load: load=1, d=7, en=0 -> q=7 after one edge; then load=1, d=12 -> q=9; load with en=1, up=1, d=3 -> q=3.
REQ-037 Hold: en=0, load=0 for 5 edges at q=4 -> q stays 4, tc=0.
REQ-038 Async reset: count to 5, then drop rst_n between edges -> q=0 and qbar=4'hF before the next edge; q=1 one edge after release with en=1, up=1.
REQ-039 JK_COUNTER_SAT_EN build: q=9, en=1, up=1 for 3 edges -> q stays 9; q=0, up=0 -> q stays 0; qbar==~q checked every cycle in all scenarios.
